// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and drawing-command types for the VGA draw path.
package fb_pkg;

  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int COORD_W   = 11;
  localparam int COLOR_W   = 8;

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} fill_state_t;

  typedef struct packed {
    logic               clear;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COLOR_W-1:0] color;
  } fb_cmd_t;

  function automatic logic [COORD_W-1:0] coord_min(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [COORD_W-1:0] coord_max(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
    return (a < b) ? b : a;
  endfunction

endpackage

// File: rtl/fb_rect_clip.sv
// Orders rectangle corners, clips them to the visible screen and flags rectangles
// that fall entirely off-screen. Purely combinational.
module fb_rect_clip
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT
) (
  input  logic               clear,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] xl,
  output logic [COORD_W-1:0] xr,
  output logic [COORD_W-1:0] yt,
  output logic [COORD_W-1:0] yb,
  output logic               empty
);

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

  logic [COORD_W-1:0] lo_x, hi_x, lo_y, hi_y;

  // Emptiness is judged on the near edges only; far edges are simply clamped.
  always_comb begin
    lo_x  = coord_min(x0, x1);
    hi_x  = coord_max(x0, x1);
    lo_y  = coord_min(y0, y1);
    hi_y  = coord_max(y0, y1);
    xl    = lo_x;
    yt    = lo_y;
    xr    = coord_min(hi_x, X_LAST);
    yb    = coord_min(hi_y, Y_LAST);
    empty = (lo_x > X_LAST) || (lo_y > Y_LAST);
    if (clear) begin
      xl    = '0;
      yt    = '0;
      xr    = X_LAST;
      yb    = Y_LAST;
      empty = 1'b0;
    end
  end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle-fill / clear-screen engine driving the 640x480 framebuffer write port
// at one pixel per clock in raster order.
module fb_rect_writer
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_clear,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COLOR_W-1:0] VGA_Cin,
  output logic               pixel_write,
  output logic               busy,
  output logic               done
);

  fill_state_t        state, next_state;
  fb_cmd_t            cmd_q;
  logic [COORD_W-1:0] cur_x, cur_y, bound_xl, bound_xr, bound_yb;
  logic [COORD_W-1:0] clip_xl, clip_xr, clip_yt, clip_yb;
  logic               clip_empty;
  logic               accept, last_pixel;

  // Ready is masked by reset so nothing can be accepted while the engine is held.
  assign cmd_ready  = (state == IDLE) && !reset;
  assign accept     = cmd_valid && cmd_ready;
  assign last_pixel = (cur_x == bound_xr) && (cur_y == bound_yb);

  fb_rect_clip #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_clip (
    .clear(cmd_q.clear),
    .x0   (cmd_q.x0),
    .y0   (cmd_q.y0),
    .x1   (cmd_q.x1),
    .y1   (cmd_q.y1),
    .xl   (clip_xl),
    .xr   (clip_xr),
    .yt   (clip_yt),
    .yb   (clip_yb),
    .empty(clip_empty)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SETUP;
      SETUP:   next_state = clip_empty ? DONE : FILL;
      FILL:    if (last_pixel) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs lag the cursor by one register stage, so the last write is still
  // visible while the FSM sits in DONE; done follows on the next edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cmd_q       <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      bound_xl    <= '0;
      bound_xr    <= '0;
      bound_yb    <= '0;
      x           <= '0;
      y           <= '0;
      VGA_Cin     <= '0;
      pixel_write <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      pixel_write <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_q.clear <= cmd_clear;
            cmd_q.x0    <= cmd_x0;
            cmd_q.y0    <= cmd_y0;
            cmd_q.x1    <= cmd_x1;
            cmd_q.y1    <= cmd_y1;
            cmd_q.color <= cmd_color;
            busy        <= 1'b1;
          end
        end
        SETUP: begin
          cur_x    <= clip_xl;
          cur_y    <= clip_yt;
          bound_xl <= clip_xl;
          bound_xr <= clip_xr;
          bound_yb <= clip_yb;
        end
        FILL: begin
          x           <= cur_x;
          y           <= cur_y;
          VGA_Cin     <= cmd_q.color;
          pixel_write <= 1'b1;
          if (cur_x == bound_xr) begin
            cur_x <= bound_xl;
            if (cur_y != bound_yb) cur_y <= cur_y + COORD_W'(1);
          end else begin
            cur_x <= cur_x + COORD_W'(1);
          end
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: table vectors, random rectangles against
// a raster-order reference model, and hand-written handshake/reset sequences.
module tb_fb_rect_writer;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_clear;
  logic [10:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [7:0]  cmd_color;
  logic [10:0] x, y;
  logic [7:0]  VGA_Cin;
  logic        pixel_write;
  logic        busy;
  logic        done;

  int checks = 0;
  int fails  = 0;

  fb_rect_writer dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_clear  (cmd_clear),
    .cmd_x0     (cmd_x0),
    .cmd_y0     (cmd_y0),
    .cmd_x1     (cmd_x1),
    .cmd_y1     (cmd_y1),
    .cmd_color  (cmd_color),
    .x          (x),
    .y          (y),
    .VGA_Cin    (VGA_Cin),
    .pixel_write(pixel_write),
    .busy       (busy),
    .done       (done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic       clr;
    int         x0, y0, x1, y1;
    logic [7:0] col;
    int         count;
    int         lx, ly;
  } vec_t;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, $signed(actual),
               $signed(expected));
    end
  endtask

  // Reference geometry straight from the drawing rules.
  task automatic model_rect(input logic clr, input int x0, input int y0, input int x1,
                            input int y1, output int xl, output int xr, output int yt,
                            output int yb, output int area);
    xl = (x0 < x1) ? x0 : x1;
    xr = (x0 < x1) ? x1 : x0;
    yt = (y0 < y1) ? y0 : y1;
    yb = (y0 < y1) ? y1 : y0;
    if (xr > 639) xr = 639;
    if (yb > 479) yb = 479;
    area = (xl > 639 || yt > 479) ? 0 : (xr - xl + 1) * (yb - yt + 1);
    if (clr) begin
      xl = 0; yt = 0; xr = 639; yb = 479;
      area = 640 * 480;
    end
  endtask

  task automatic scramble_inputs();
    cmd_clear = 1'($urandom);
    cmd_x0    = 11'($urandom);
    cmd_y0    = 11'($urandom);
    cmd_x1    = 11'($urandom);
    cmd_y1    = 11'($urandom);
    cmd_color = 8'($urandom);
  endtask

  task automatic apply_stimulus(input logic clr, input int x0, input int y0, input int x1,
                                input int y1, input logic [7:0] col, input bit hold);
    @(negedge CLOCK_50);
    for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge CLOCK_50);
    check_output("ready before issue", 32'(cmd_ready), 1);
    cmd_clear = clr;
    cmd_x0    = 11'(x0);
    cmd_y0    = 11'(y0);
    cmd_x1    = 11'(x1);
    cmd_y1    = 11'(y1);
    cmd_color = col;
    cmd_valid = 1'b1;
    @(posedge CLOCK_50);
    #1;
    if (!hold) begin
      cmd_valid = 1'b0;
      scramble_inputs();
    end
  endtask

  // Follows one command from just after its handshake edge up to its done pulse.
  task automatic observe(input logic clr, input int x0, input int y0, input int x1,
                         input int y1, input logic [7:0] col, input int exp_count,
                         input int exp_lx, input int exp_ly, input string tag);
    int xl, xr, yt, yb, area, w;
    int n_wr, first_i, done_i, bad, ready_bad, busy_bad, lx, ly, ex, ey;
    logic busy_at_done;
    model_rect(clr, x0, y0, x1, y1, xl, xr, yt, yb, area);
    w = xr - xl + 1;
    n_wr = 0; first_i = -1; done_i = -1; bad = 0; ready_bad = 0; busy_bad = 0;
    lx = -1; ly = -1; busy_at_done = 1'bx;
    for (int i = 0; i < area + 10 && done_i < 0; i++) begin
      @(negedge CLOCK_50);
      if (pixel_write) begin
        if (first_i < 0) first_i = i;
        ex = xl + n_wr % w;
        ey = yt + n_wr / w;
        if (n_wr >= area || x !== 11'(ex) || y !== 11'(ey) || VGA_Cin !== col) bad++;
        lx = int'(x);
        ly = int'(y);
        n_wr++;
      end
      if (done === 1'b1) begin
        done_i = i;
        busy_at_done = busy;
      end else begin
        if (cmd_ready !== 1'b0) ready_bad++;
        if (busy !== 1'b1) busy_bad++;
      end
    end
    check_output({tag, " write count"}, n_wr, exp_count);
    check_output({tag, " first write cycle"}, first_i, (exp_count > 0) ? 2 : -1);
    check_output({tag, " done cycle"}, done_i, 2 + exp_count);
    check_output({tag, " order/value errors"}, bad, 0);
    check_output({tag, " ready while busy"}, ready_bad, 0);
    check_output({tag, " busy low early"}, busy_bad, 0);
    check_output({tag, " busy at done"}, 32'(busy_at_done), 0);
    if (exp_count > 0) begin
      check_output({tag, " last x"}, lx, exp_lx);
      check_output({tag, " last y"}, ly, exp_ly);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   xl, xr, yt, yb, area, wr, cnt, bad, first_i, rx0, ry0, rx1, ry1;
    logic [7:0] rcol;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_clear = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0;
    cmd_color = '0;

    // Reset state.
    repeat (2) @(negedge CLOCK_50);
    check_output("reset cmd_ready", 32'(cmd_ready), 0);
    check_output("reset pixel_write", 32'(pixel_write), 0);
    check_output("reset busy", 32'(busy), 0);
    check_output("reset done", 32'(done), 0);
    check_output("reset x", 32'(x), 0);
    check_output("reset y", 32'(y), 0);
    check_output("reset VGA_Cin", 32'(VGA_Cin), 0);
    reset = 1'b0;
    #1;
    check_output("ready after reset release", 32'(cmd_ready), 1);

    vecs[0] = '{1'b0,   5,   7,    5,   7, 8'hAA,   1,   5,   7};
    vecs[1] = '{1'b0,  12,   4,   10,   3, 8'h3C,   6,  12,   4};
    vecs[2] = '{1'b0, 630, 470,  700, 900, 8'h55, 100, 639, 479};
    vecs[3] = '{1'b0, 650,  10,  660,  20, 8'h77,   0,   0,   0};
    vecs[4] = '{1'b0,   0, 479,    3, 520, 8'h11,   4,   3, 479};
    vecs[5] = '{1'b0, 639,   0, 2047,   1, 8'hF0,   2, 639,   1};
    vecs[6] = '{1'b0, 110, 600,  100, 500, 8'h99,   0,   0,   0};
    vecs[7] = '{1'b0, 200,  50,  197,  50, 8'h01,   4, 200,  50};

    for (int v = 0; v < 8; v++) begin
      apply_stimulus(vecs[v].clr, vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1,
                     vecs[v].col, 1'b0);
      observe(vecs[v].clr, vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1, vecs[v].col,
              vecs[v].count, vecs[v].lx, vecs[v].ly, $sformatf("vec%0d", v));
    end

    // Random rectangles, some hanging off the right or bottom edge.
    for (int r = 0; r < 10; r++) begin
      rx0  = $urandom_range(0, 700);
      ry0  = $urandom_range(0, 520);
      rx1  = rx0 + $urandom_range(0, 12);
      ry1  = ry0 + $urandom_range(0, 6);
      rcol = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        rx0 = rx0 ^ rx1; rx1 = rx0 ^ rx1; rx0 = rx0 ^ rx1;
      end
      model_rect(1'b0, rx0, ry0, rx1, ry1, xl, xr, yt, yb, area);
      apply_stimulus(1'b0, rx0, ry0, rx1, ry1, rcol, 1'b0);
      observe(1'b0, rx0, ry0, rx1, ry1, rcol, area, xr, yb, $sformatf("rand%0d", r));
    end

    // A second command held on the bus during a fill is taken only after done.
    apply_stimulus(1'b0, 20, 30, 23, 32, 8'h81, 1'b1);
    cmd_clear = 1'b0;
    cmd_x0 = 11'd301; cmd_y0 = 11'd201; cmd_x1 = 11'd300; cmd_y1 = 11'd200;
    cmd_color = 8'h42;
    observe(1'b0, 20, 30, 23, 32, 8'h81, 12, 23, 32, "held first");
    @(posedge CLOCK_50);
    #1;
    cmd_valid = 1'b0;
    scramble_inputs();
    observe(1'b0, 301, 201, 300, 200, 8'h42, 4, 301, 201, "held second");

    // Reset in the middle of a 20x20 fill.
    apply_stimulus(1'b0, 100, 100, 119, 119, 8'h5A, 1'b0);
    wr = 0;
    for (int i = 0; i < 200 && wr < 50; i++) begin
      @(negedge CLOCK_50);
      if (pixel_write === 1'b1) wr++;
    end
    check_output("midfill writes before reset", wr, 50);
    reset = 1'b1;
    #1;
    check_output("midfill pixel_write async", 32'(pixel_write), 0);
    check_output("midfill busy async", 32'(busy), 0);
    check_output("midfill x async", 32'(x), 0);
    cnt = 0;
    repeat (3) begin
      @(negedge CLOCK_50);
      if (done !== 1'b0 || cmd_ready !== 1'b0) cnt++;
    end
    check_output("midfill during reset", cnt, 0);
    reset = 1'b0;
    #1;
    check_output("midfill ready after release", 32'(cmd_ready), 1);
    cnt = 0;
    repeat (5) begin
      @(negedge CLOCK_50);
      if (done !== 1'b0 || pixel_write !== 1'b0) cnt++;
    end
    check_output("midfill abandoned", cnt, 0);
    apply_stimulus(1'b0, 7, 9, 8, 10, 8'hC3, 1'b0);
    observe(1'b0, 7, 9, 8, 10, 8'hC3, 4, 8, 10, "after reset");

    // Clear ignores its (off-screen) corners; follow the first few lines, then abort.
    apply_stimulus(1'b1, 700, 700, 800, 800, 8'h00, 1'b0);
    cnt = 0; bad = 0; first_i = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLOCK_50);
      if (pixel_write === 1'b1) begin
        if (first_i < 0) first_i = i;
        if (x !== 11'(cnt % 640) || y !== 11'(cnt / 640) || VGA_Cin !== 8'h00) bad++;
        cnt++;
      end
      if (done !== 1'b0) bad++;
    end
    check_output("clear first write cycle", first_i, 2);
    check_output("clear write count", cnt, 2998);
    check_output("clear order errors", bad, 0);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    apply_stimulus(1'b0, 639, 479, 639, 479, 8'hE7, 1'b0);
    observe(1'b0, 639, 479, 639, 479, 8'hE7, 1, 639, 479, "corner pixel");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
